// File: rtl/switch_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : switch_alloc                                                  |
// | Purpose  : Wormhole switch allocator for an M_IN x N_OUT crossbar.       |
// |            Each output column is either IDLE (round-robin arbitration    |
// |            among requesting inputs) or LOCKED to one owner until that    |
// |            owner's tail flit transfers.                                  |
// | Ports    : clk            - sole clock, rising edge                      |
// |            rst_n          - asynchronous active-low reset                |
// |            req            - bit i*N_OUT+j: input i has a flit for out j  |
// |            req_tail       - flit presented by input i is a tail          |
// |            out_ready      - output j has downstream credit               |
// |            grant          - input i transfers (buffer pop) this cycle    |
// |            xpoints_enable - crosspoint enables, i*N_OUT+j mapping        |
// |            err_timeout    - one-cycle pulse on forced lock release       |
// | Options  : SA_WATCHDOG_EN - per-output 8-bit stall watchdog that breaks  |
// |            a lock after WD_LIMIT cycles without a transfer               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module switch_alloc #(
  parameter int VC_NUM   = 2,
  parameter int PORT_NUM = 5,
  parameter int M_IN     = VC_NUM * PORT_NUM,
  parameter int N_OUT    = PORT_NUM,
  parameter int WD_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [M_IN*N_OUT-1:0] req,
  input  logic [M_IN-1:0]       req_tail,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [M_IN-1:0]       grant,
  output logic [M_IN*N_OUT-1:0] xpoints_enable,
  output logic [N_OUT-1:0]      err_timeout
);

  localparam int            IW      = (M_IN > 1) ? $clog2(M_IN) : 1;
  localparam logic [IW-1:0] LAST_IN = IW'(M_IN - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        state_q [N_OUT];
  state_e        state_d [N_OUT];
  logic [IW-1:0] owner_q [N_OUT];
  logic [IW-1:0] owner_d [N_OUT];
  logic [IW-1:0] rr_q    [N_OUT];
  logic [IW-1:0] rr_d    [N_OUT];
  logic [IW-1:0] sel     [N_OUT];

  logic [M_IN*N_OUT-1:0] req_eff;
  logic [M_IN*N_OUT-1:0] en;
  logic [N_OUT-1:0]      xfer;
  logic [N_OUT-1:0]      wd_fire;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IN) ? '0 : idx + 1'b1;
  endfunction

  // Requests are one-hot per input: keep only the lowest requested output.
  // This also guarantees at most one enable per crossbar row.
  always_comb begin : p_req_filter
    logic hit;
    hit     = 1'b0;
    req_eff = '0;
    for (int i = 0; i < M_IN; i++) begin
      hit = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        if (!hit && req[i*N_OUT + j]) begin
          req_eff[i*N_OUT + j] = 1'b1;
          hit                  = 1'b1;
        end
      end
    end
  end

  // Per-column arbitration. A locked column only serves its owner; an idle
  // column scans from rr forward, wrapping, and takes the first requester.
  always_comb begin : p_arb
    int idx;
    int own;
    idx  = 0;
    own  = 0;
    en   = '0;
    xfer = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sel[j] = '0;
      if (out_ready[j]) begin
        if (state_q[j] == ST_LOCKED) begin
          own = int'(owner_q[j]);
          if (req_eff[own*N_OUT + j]) begin
            xfer[j] = 1'b1;
            sel[j]  = owner_q[j];
          end
        end else begin
          for (int k = 0; k < M_IN; k++) begin
            idx = int'(rr_q[j]) + k;
            if (idx >= M_IN) idx = idx - M_IN;
            if (!xfer[j] && req_eff[idx*N_OUT + j]) begin
              xfer[j] = 1'b1;
              sel[j]  = IW'(idx);
            end
          end
        end
      end
      if (xfer[j]) en[int'(sel[j])*N_OUT + j] = 1'b1;
    end
  end

  // Lock bookkeeping. A tail transfer (including a head+tail single flit)
  // releases the column and moves the pointer past the sender.
  always_comb begin : p_next
    for (int j = 0; j < N_OUT; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      rr_d[j]    = rr_q[j];
      if (xfer[j]) begin
        if (req_tail[sel[j]]) begin
          state_d[j] = ST_IDLE;
          rr_d[j]    = next_idx(sel[j]);
        end else begin
          state_d[j] = ST_LOCKED;
          owner_d[j] = sel[j];
        end
      end else if (wd_fire[j]) begin
        state_d[j] = ST_IDLE;
        rr_d[j]    = next_idx(owner_q[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) begin
        state_q[j] <= ST_IDLE;
        owner_q[j] <= '0;
        rr_q[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        rr_q[j]    <= rr_d[j];
      end
    end
  end

`ifdef SA_WATCHDOG_EN
  localparam logic [7:0] WD_MAX = 8'(WD_LIMIT);

  logic [7:0] stall_q [N_OUT];
  logic [7:0] stall_d [N_OUT];

  // The release fires in the cycle the counter sits at the limit with still
  // no transfer; a late transfer by the owner wins over the timeout.
  always_comb begin : p_wd_next
    for (int j = 0; j < N_OUT; j++) begin
      stall_d[j] = stall_q[j];
      wd_fire[j] = 1'b0;
      if (xfer[j]) begin
        stall_d[j] = '0;
      end else if (state_q[j] == ST_LOCKED) begin
        if (stall_q[j] == WD_MAX) begin
          wd_fire[j] = 1'b1;
          stall_d[j] = '0;
        end else begin
          stall_d[j] = stall_q[j] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_wd_state
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) stall_q[j] <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) stall_q[j] <= stall_d[j];
    end
  end
`else
  assign wd_fire = '0;
`endif

  // Outputs are gated by rst_n so nothing is enabled while reset is held,
  // even though idle columns would otherwise arbitrate combinationally.
  always_comb begin : p_out
    xpoints_enable = rst_n ? en : '0;
    err_timeout    = rst_n ? wd_fire : '0;
    grant          = '0;
    for (int i = 0; i < M_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (rst_n && en[i*N_OUT + j]) grant[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_switch_alloc                                               |
// | Purpose  : Self-checking bench for switch_alloc (M_IN=10, N_OUT=5).      |
// |            Directed scenarios plus random traffic against a behavioural  |
// |            reference model of the allocation rules.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_switch_alloc;

  localparam int M  = 10;
  localparam int N  = 5;
  localparam int WD = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [M*N-1:0] req;
  logic [M-1:0]   req_tail;
  logic [N-1:0]   out_ready;
  logic [M-1:0]   grant;
  logic [M*N-1:0] xpoints_enable;
  logic [N-1:0]   err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_alloc #(
    .VC_NUM   (2),
    .PORT_NUM (5),
    .M_IN     (M),
    .N_OUT    (N),
    .WD_LIMIT (WD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_tail       (req_tail),
    .out_ready      (out_ready),
    .grant          (grant),
    .xpoints_enable (xpoints_enable),
    .err_timeout    (err_timeout)
  );

  // Reference model: per-output lock flag, owner, pointer, stall count.
  bit           m_locked [N];
  int           m_owner  [N];
  int           m_rr     [N];
  int           m_stall  [N];
  int           m_win    [N];
  logic [M*N-1:0] exp_en;
  logic [M-1:0]   exp_gnt;
  logic [N-1:0]   exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] onehot(input int i);
    logic [M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int lowest_out(input int i);
    for (int j = 0; j < N; j++) if (req[i*N + j]) return j;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_locked[j] = 1'b0;
      m_owner[j]  = 0;
      m_rr[j]     = 0;
      m_stall[j]  = 0;
      m_win[j]    = -1;
    end
  endfunction

  // Winner of an idle column = requester with the smallest cyclic distance
  // from the pointer.
  function automatic void model_eval();
    int want [M];
    int best_d;
    int d;
    exp_en  = '0;
    exp_gnt = '0;
    exp_err = '0;
    for (int i = 0; i < M; i++) want[i] = lowest_out(i);
    for (int j = 0; j < N; j++) begin
      m_win[j] = -1;
      if (rst_n && out_ready[j]) begin
        if (m_locked[j]) begin
          if (want[m_owner[j]] == j) m_win[j] = m_owner[j];
        end else begin
          best_d = M;
          for (int i = 0; i < M; i++) begin
            d = (i - m_rr[j] + M) % M;
            if (want[i] == j && d < best_d) begin
              best_d   = d;
              m_win[j] = i;
            end
          end
        end
      end
      if (m_win[j] >= 0) begin
        exp_en[m_win[j]*N + j] = 1'b1;
        exp_gnt[m_win[j]]      = 1'b1;
      end
`ifdef SA_WATCHDOG_EN
      if (rst_n && m_locked[j] && m_win[j] < 0 && m_stall[j] == WD) exp_err[j] = 1'b1;
`endif
    end
  endfunction

  function automatic void model_commit();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int j = 0; j < N; j++) begin
      if (m_win[j] >= 0) begin
        m_stall[j] = 0;
        if (req_tail[m_win[j]]) begin
          m_locked[j] = 1'b0;
          m_rr[j]     = (m_win[j] + 1) % M;
        end else begin
          m_locked[j] = 1'b1;
          m_owner[j]  = m_win[j];
        end
      end else if (m_locked[j]) begin
`ifdef SA_WATCHDOG_EN
        if (m_stall[j] == WD) begin
          m_locked[j] = 1'b0;
          m_rr[j]     = (m_owner[j] + 1) % M;
          m_stall[j]  = 0;
        end else begin
          m_stall[j]++;
        end
`endif
      end
    end
  endfunction

  // One cycle: inputs already driven; sample at negedge, update at posedge.
  task automatic step(output logic [M-1:0] g_obs, output logic [N-1:0] e_obs);
    @(negedge clk);
    model_eval();
    check("grant", grant, exp_gnt);
    check("xpoints", xpoints_enable, exp_en);
    check("err_timeout", err_timeout, exp_err);
    g_obs = grant;
    e_obs = err_timeout;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    logic [M-1:0] g;
    logic [N-1:0] e;
    rst_n     = 1'b0;
    req       = '0;
    req_tail  = '0;
    out_ready = '1;
    step(g, e);
    rst_n = 1'b1;
  endtask

  initial begin : p_main
    logic [M-1:0]   g;
    logic [N-1:0]   e;
    logic [M*N-1:0] col1_mask;
    int             rr_seq [4];
    int             fire_cycle;

    model_reset();
    rst_n     = 1'b0;
    req       = '1;
    req_tail  = '0;
    out_ready = '1;
    @(posedge clk);
    #1;

    // Reset holds every output low even with all requests asserted.
    step(g, e);
    check("rst_grant", g, '0);
    check("rst_err", e, '0);
    rst_n = 1'b1;

    // Round robin on output 2 among inputs 0, 3, 7, all single-flit.
    do_reset();
    rr_seq = '{0, 3, 7, 0};
    req_tail = '1;
    req[0*N + 2] = 1'b1;
    req[3*N + 2] = 1'b1;
    req[7*N + 2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(g, e);
      check("rr_order", g, onehot(rr_seq[k]));
    end

    // Lock: input 4 sends 3 flits to output 1 while input 5 waits.
    do_reset();
    req[4*N + 1] = 1'b1;
    req[5*N + 1] = 1'b1;
    req_tail[5]  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      req_tail[4] = (f == 2);
      if (f == 3) req[4*N + 1] = 1'b0;
      step(g, e);
      check("lock_seq", g, (f < 3) ? onehot(4) : onehot(5));
    end

    // Backpressure mid-packet on output 1.
    do_reset();
    col1_mask = '0;
    for (int i = 0; i < M; i++) col1_mask[i*N + 1] = 1'b1;
    req[4*N + 1] = 1'b1;
    req[5*N + 1] = 1'b1;
    req_tail[5]  = 1'b1;
    step(g, e);
    check("bp_head", g, onehot(4));
    out_ready[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(g, e);
      check("bp_stall_grant", g, '0);
      check("bp_stall_col", xpoints_enable & col1_mask, '0);
    end
    out_ready[1] = 1'b1;
    req_tail[4]  = 1'b1;
    step(g, e);
    check("bp_resume", g, onehot(4));
    req[4*N + 1] = 1'b0;
    step(g, e);
    check("bp_next", g, onehot(5));

    // Parallel: inputs 0 and 1 to outputs 0 and 1 in the same cycle.
    do_reset();
    req_tail = '1;
    req[0]   = 1'b1;
    req[6]   = 1'b1;
    @(negedge clk);
    check("par_xpoints", xpoints_enable, 50'h41);
    step(g, e);
    check("par_grant", g, 10'h003);

    // Multi-hot request row: only the lowest output is considered.
    do_reset();
    req_tail       = '1;
    req[3*N + 1]   = 1'b1;
    req[3*N + 4]   = 1'b1;
    @(negedge clk);
    check("lowest_only", xpoints_enable, 50'h1 << 16);
    step(g, e);

`ifdef SA_WATCHDOG_EN
    // Owner abandons a lock; watchdog breaks it and input 6 gets through.
    do_reset();
    req[2*N + 3] = 1'b1;
    step(g, e);
    check("wd_head", g, onehot(2));
    req[2*N + 3] = 1'b0;
    req[6*N + 3] = 1'b1;
    req_tail[6]  = 1'b1;
    fire_cycle   = -1;
    for (int c = 1; c <= 300 && fire_cycle < 0; c++) begin
      step(g, e);
      if (e[3]) fire_cycle = c;
    end
    check("wd_fire_cycle", 64'(fire_cycle), 64'd256);
    step(g, e);
    check("wd_rearb", g, onehot(6));
`else
    fire_cycle = 0;
    // Without the watchdog an abandoned lock persists.
    do_reset();
    req[2*N + 3] = 1'b1;
    step(g, e);
    req[2*N + 3] = 1'b0;
    req[6*N + 3] = 1'b1;
    req_tail[6]  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step(g, e);
      if (g[6] || e != '0) fire_cycle++;
    end
    check("lock_persist", 64'(fire_cycle), 64'd0);
`endif

    // Random traffic with occasional mid-run resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req   = '0;
      for (int i = 0; i < M; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: req[i*N + $urandom_range(0, N-1)] = 1'b1;
          5: begin
            req[i*N + $urandom_range(0, N-1)] = 1'b1;
            req[i*N + $urandom_range(0, N-1)] = 1'b1;
          end
          default: ;
        endcase
        req_tail[i] = ($urandom_range(0, 2) == 0);
      end
      for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 6) != 0);
      step(g, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
